// File: rtl/rand_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : rand_uart_tx
// Description : Captures the generator's random byte on a programmable
//               sample period and transmits it as a UART frame (8N1, or
//               8E1 when RAND_UART_PARITY_EN is defined). Exposes the last
//               captured byte and a sticky overrun flag.
// Config      : `RAND_UART_PARITY_EN adds an even-parity bit between the
//               data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_uart_tx #(
  parameter logic [23:0] SAMPLE_PERIOD = 24'd10_000_000,
  parameter logic [15:0] CLKS_PER_BIT  = 16'd87
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] rand_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic [7:0] sample_o,
  output logic       overrun_o
);

`ifdef RAND_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  localparam logic [23:0] c_TICK_AT  = SAMPLE_PERIOD - 24'd1;
  localparam logic [15:0] c_BIT_LAST = CLKS_PER_BIT - 16'd1;

  state_t      r_state;
  logic [23:0] r_timer;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic [7:0]  r_sample;
  logic        r_overrun;

  logic w_tick;
  logic w_bit_end;
  logic w_accept;

  // A tick is only meaningful while the timer is enabled.
  assign w_tick    = en_i && (r_timer == c_TICK_AT);
  assign w_bit_end = (r_baud == c_BIT_LAST);
  // Accept when idle, or exactly on the last clock of the stop bit so
  // back-to-back frames run with no idle gap.
  assign w_accept  = w_tick &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  // Sample-period timer: free-runs 0..SAMPLE_PERIOD-1 while enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timer <= 24'd0;
    end else if (!en_i || w_tick) begin
      r_timer <= 24'd0;
    end else begin
      r_timer <= r_timer + 24'd1;
    end
  end

  // Frame FSM with registered line, busy, sample and overrun outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_sample  <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      if (w_tick && !w_accept) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        r_state  <= S_START;
        r_shift  <= rand_i;
        r_sample <= rand_i;
        r_tx     <= 1'b0;
        r_busy   <= 1'b1;
        r_baud   <= 16'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_baud <= 16'd0;
          end
          S_START: begin
            if (w_bit_end) begin
              r_state   <= S_DATA;
              r_tx      <= r_shift[0];
              r_bit_idx <= 3'd0;
              r_baud    <= 16'd0;
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_baud <= 16'd0;
              if (r_bit_idx == 3'd7) begin
`ifdef RAND_UART_PARITY_EN
                r_state <= S_PARITY;
                r_tx    <= ^r_sample;
`else
                r_state <= S_STOP;
                r_tx    <= 1'b1;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {1'b0, r_shift[7:1]};
                r_tx      <= r_shift[1];
              end
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
`ifdef RAND_UART_PARITY_EN
          S_PARITY: begin
            if (w_bit_end) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
              r_baud  <= 16'd0;
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
`endif
          S_STOP: begin
            if (w_bit_end) begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_baud  <= 16'd0;
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_baud  <= 16'd0;
          end
        endcase
      end
    end
  end

  assign tx_o      = r_tx;
  assign busy_o    = r_busy;
  assign sample_o  = r_sample;
  assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rand_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_uart_tx
// Description : Self-checking bench for rand_uart_tx. Three instances with
//               different sample periods; expected line activity is derived
//               from tick times, frame length and captured bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_uart_tx;

  localparam int c_CPB = 4;
`ifdef RAND_UART_PARITY_EN
  localparam int c_FRAME_BITS = 11;
`else
  localparam int c_FRAME_BITS = 10;
`endif
  localparam int c_FRAME_LEN = c_FRAME_BITS * c_CPB;
  localparam int c_SP_A = 64;
  localparam int c_SP_B = 32;
  localparam int c_SP_C = c_FRAME_LEN;

  logic       clk = 1'b0;
  logic [2:0] rst_r;
  logic [2:0] en_r;
  logic [7:0] rnd [3];
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] ovr;
  logic [7:0] smp [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rand_uart_tx #(.SAMPLE_PERIOD(24'(c_SP_A)), .CLKS_PER_BIT(16'(c_CPB))) u_dut_a (
    .clk_i(clk), .rst_i(rst_r[0]), .en_i(en_r[0]), .rand_i(rnd[0]),
    .tx_o(tx[0]), .busy_o(busy[0]), .sample_o(smp[0]), .overrun_o(ovr[0]));

  rand_uart_tx #(.SAMPLE_PERIOD(24'(c_SP_B)), .CLKS_PER_BIT(16'(c_CPB))) u_dut_b (
    .clk_i(clk), .rst_i(rst_r[1]), .en_i(en_r[1]), .rand_i(rnd[1]),
    .tx_o(tx[1]), .busy_o(busy[1]), .sample_o(smp[1]), .overrun_o(ovr[1]));

  rand_uart_tx #(.SAMPLE_PERIOD(24'(c_SP_C)), .CLKS_PER_BIT(16'(c_CPB))) u_dut_c (
    .clk_i(clk), .rst_i(rst_r[2]), .en_i(en_r[2]), .rand_i(rnd[2]),
    .tx_o(tx[2]), .busy_o(busy[2]), .sample_o(smp[2]), .overrun_o(ovr[2]));

  // Line levels of one frame, index 0 = start bit.
  function automatic logic [c_FRAME_BITS-1:0] frame_bits(input logic [7:0] b);
`ifdef RAND_UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Runs one instance with en_i high for ncyc clocks. Ticks fall on clock
  // edges k*sp counted from the first edge with en_i high; a tick is taken
  // when the previous frame has finished by that edge, otherwise it is an
  // overrun. rand_i carries the tick byte only on tick edges.
  task automatic run_stream(input int d, input int sp, input int ncyc,
                            input logic [7:0] first, input bit use_first,
                            input bit do_rst, input string tag);
    logic [7:0] tq[$];
    int         fs[$];
    logic [7:0] fb[$];
    int         free_at, rej, nt;
    logic [7:0] b, exp_sample;
    logic       exp_tx, exp_busy, exp_ovr;
    logic [c_FRAME_BITS-1:0] bits;
    nt = ncyc / sp + 1;
    for (int k = 0; k <= nt; k++) begin
      b = 8'($urandom);
      if (k == 1 && use_first) b = first;
      tq.push_back(b);
    end
    free_at = 0;
    rej = ncyc + 1;
    for (int k = 1; k * sp <= ncyc; k++) begin
      if (k * sp >= free_at) begin
        fs.push_back(k * sp);
        fb.push_back(tq[k]);
        free_at = k * sp + c_FRAME_LEN;
      end else if (rej > ncyc) begin
        rej = k * sp;
      end
    end
    if (do_rst) begin
      rst_r[d] = 1'b1;
      en_r[d]  = 1'b0;
      @(negedge clk);
      rst_r[d] = 1'b0;
    end
    en_r[d] = 1'b1;
    rnd[d]  = 8'($urandom);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      exp_tx = 1'b1;
      exp_busy = 1'b0;
      exp_sample = 8'h00;
      exp_ovr = (rej <= n);
      foreach (fs[f]) begin
        if (fs[f] <= n) begin
          exp_sample = fb[f];
          if (n < fs[f] + c_FRAME_LEN) begin
            bits = frame_bits(fb[f]);
            exp_tx = bits[(n - fs[f]) / c_CPB];
            exp_busy = 1'b1;
          end
        end
      end
      vectors++;
      if (tx[d] !== exp_tx) begin
        miscompares++;
        $display("FAIL %s tx dut=%0d cyc=%0d got=%b exp=%b", tag, d, n, tx[d], exp_tx);
      end
      vectors++;
      if (busy[d] !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy dut=%0d cyc=%0d got=%b exp=%b", tag, d, n, busy[d], exp_busy);
      end
      vectors++;
      if (ovr[d] !== exp_ovr) begin
        miscompares++;
        $display("FAIL %s overrun dut=%0d cyc=%0d got=%b exp=%b", tag, d, n, ovr[d], exp_ovr);
      end
      vectors++;
      if (smp[d] !== exp_sample) begin
        miscompares++;
        $display("FAIL %s sample dut=%0d cyc=%0d got=%h exp=%h", tag, d, n, smp[d], exp_sample);
      end
      rnd[d] = ((n + 1) % sp == 0) ? tq[(n + 1) / sp] : 8'($urandom);
    end
    en_r[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_r = 3'b111;
    en_r  = 3'b000;
    for (int d = 0; d < 3; d++) rnd[d] = 8'($urandom);
    #1;
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || smp[d] !== 8'h00 || ovr[d] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset dut=%0d step=%0d got tx=%b busy=%b sample=%h ovr=%b exp 1 0 00 0",
                   d, c, tx[d], busy[d], smp[d], ovr[d]);
        end
      end
      @(negedge clk);
      en_r = 3'($urandom);
      for (int d = 0; d < 3; d++) rnd[d] = 8'($urandom);
    end
  endtask

  task automatic test_basic();
    run_stream(0, c_SP_A, c_SP_A + c_FRAME_LEN + 4, 8'hA5, 1'b1, 1'b1, "basic_a5");
    run_stream(0, c_SP_A, c_SP_A + c_FRAME_LEN + 4, 8'h00, 1'b0, 1'b1, "basic_rand");
  endtask

  task automatic test_overrun();
    run_stream(1, c_SP_B, 3 * c_SP_B + c_FRAME_LEN + 4, 8'h00, 1'b0, 1'b1, "overrun");
  endtask

  task automatic test_back_to_back();
    run_stream(2, c_SP_C, 5 * c_SP_C + 6, 8'h00, 1'b0, 1'b1, "back_to_back");
  endtask

  task automatic test_parity();
    run_stream(0, c_SP_A, c_SP_A + c_FRAME_LEN + 2, 8'h07, 1'b1, 1'b1, "parity_07");
    run_stream(0, c_SP_A, c_SP_A + c_FRAME_LEN + 2, 8'h03, 1'b1, 1'b1, "parity_03");
  endtask

  task automatic test_reset_midframe();
    rst_r[0] = 1'b1;
    en_r[0]  = 1'b0;
    @(negedge clk);
    rst_r[0] = 1'b0;
    en_r[0]  = 1'b1;
    rnd[0]   = 8'($urandom);
    // Start bit begins at edge 64; data bit 3 occupies edges 64+16..64+19.
    repeat (c_SP_A + 17) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe busy_before got=%b exp=1", busy[0]);
    end
    rst_r[0] = 1'b1;
    #1;
    vectors++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe async_reset got tx=%b busy=%b exp tx=1 busy=0", tx[0], busy[0]);
    end
    @(negedge clk);
    rst_r[0] = 1'b0;
    run_stream(0, c_SP_A, c_SP_A + c_FRAME_LEN + 2, 8'h00, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
